// File: rtl/mini_alu_16bit_sub.sv
// mini_alu_16bit_sub: registered two's-complement subtractor (SUB slice of the mini ALU).
// Computes diff = data0 - data1 with signed-overflow and unsigned-borrow flags, one cycle
// of latency, one new operation per cycle. valid marks results computed since reset.

module mini_alu_16bit_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] diff,
  output logic             overflow,
  output logic             borrow,
  output logic             valid
);

  // Extra top bit of the intermediate captures the unsigned borrow.
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             overflow_d, overflow_q;
  logic             borrow_d, borrow_q;
  logic             valid_q;

  // Next-state arithmetic: widened subtract, then derive the flags from its result.
  always_comb begin
    sub_full   = {1'b0, data0} - {1'b0, data1};
    diff_d     = sub_full[WIDTH-1:0];
    borrow_d   = sub_full[WIDTH];
    // Signed overflow only when operand signs differ and the result sign flips from data0.
    overflow_d = (data0[WIDTH-1] != data1[WIDTH-1]) && (diff_d[WIDTH-1] != data0[WIDTH-1]);
  end

  // Output registers; synchronous reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= '0;
      overflow_q <= 1'b0;
      borrow_q   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      diff_q     <= diff_d;
      overflow_q <= overflow_d;
      borrow_q   <= borrow_d;
      valid_q    <= 1'b1;
    end
  end

  assign diff     = diff_q;
  assign overflow = overflow_q;
  assign borrow   = borrow_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_mini_alu_16bit_sub.sv
// Self-checking bench for mini_alu_16bit_sub: directed boundary cases plus a random
// regression against a plain-integer reference model.

module tb_mini_alu_16bit_sub;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] diff;
  logic             overflow;
  logic             borrow;
  logic             valid;

  int n_checks = 0;
  int n_pass   = 0;

  mini_alu_16bit_sub #(
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data0    (data0),
    .data1    (data1),
    .diff     (diff),
    .overflow (overflow),
    .borrow   (borrow),
    .valid    (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model from arithmetic rules on plain integers.
  task automatic ref_sub(input int a, input int b, output int e_diff, output int e_ovf,
                         output int e_brw);
    int sa, sb, sd;
    e_diff = (a - b + 65536) % 65536;
    e_brw  = (a < b) ? 1 : 0;
    sa     = (a >= 32768) ? a - 65536 : a;
    sb     = (b >= 32768) ? b - 65536 : b;
    sd     = sa - sb;
    e_ovf  = (sd > 32767 || sd < -32768) ? 1 : 0;
  endtask

  // Drive one operand pair, clock it in, and check outputs just after the edge.
  task automatic step(input string tag, input int a, input int b);
    int e_diff, e_ovf, e_brw;
    data0 = a[WIDTH-1:0];
    data1 = b[WIDTH-1:0];
    @(posedge clk);
    #1;
    if (rst) begin
      check({tag, ".diff"}, 32'(diff), 32'h0);
      check({tag, ".ovf"}, 32'(overflow), 32'h0);
      check({tag, ".brw"}, 32'(borrow), 32'h0);
      check({tag, ".valid"}, 32'(valid), 32'h0);
    end else begin
      ref_sub(a, b, e_diff, e_ovf, e_brw);
      check({tag, ".diff"}, 32'(diff), 32'(e_diff));
      check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
      check({tag, ".brw"}, 32'(borrow), 32'(e_brw));
      check({tag, ".valid"}, 32'(valid), 32'h1);
    end
  endtask

  initial begin
    int a, b;
    rst   = 1'b1;
    data0 = '0;
    data1 = '0;

    // Reset held for two edges with live inputs, then released.
    step("rst0", 'h1234, 'h0001);
    step("rst1", 'h1234, 'h0001);
    rst = 1'b0;
    step("rel", 'h1234, 'h0001);
    check("rel_diff_const", 32'(diff), 32'h1233);

    // Directed boundaries.
    step("eq", 'hA5A5, 'hA5A5);
    step("wrap", 'h0000, 'h0001);
    check("wrap_diff_const", 32'(diff), 32'hFFFF);
    step("small", 'h0005, 'h0003);
    step("ovf_neg", 'h8000, 'h0001);
    check("ovf_neg_const", 32'(overflow), 32'h1);
    step("ovf_pos", 'h7FFF, 'hFFFF);
    check("ovf_pos_diff_const", 32'(diff), 32'h8000);
    step("noovf", 'hFFFF, 'h0001);
    step("min_min", 'h8000, 'h8000);

    // Back-to-back changes with a reset in the middle.
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      rst = (i == 4);
      step("b2b", a, b);
    end
    rst = 1'b0;
    step("resume", 'h1000, 'h0FFF);

    // Random regression.
    for (int i = 0; i < 10000; i++) begin
      a = int'($urandom_range(0, 65535));
      b = int'($urandom_range(0, 65535));
      step("rand", a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
